// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, credit-limited
// by a small instruction FIFO, with redirect flush and stale-response discard.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i
);

   localparam int unsigned PTR_W     = (BUF_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] START_PC  = RESET_PC & WORD_MASK;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state;
   logic [31:0]      fetch_pc;
   logic [31:0]      out_pc;
   logic             discard;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [31:0]      buf_pc    [BUF_DEPTH];
   logic [31:0]      buf_instr [BUF_DEPTH];

   logic grant;
   logic rsp;
   logic push;
   logic pop;

   // Request only from REQ when the buffer has room; a redirect suppresses it.
   always_comb begin
      imem_req_o = 1'b0;
      if ((state == REQ) && (count < CNT_W'(BUF_DEPTH)) && !redirect_i) begin
         imem_req_o = 1'b1;
      end
   end

   assign grant         = imem_req_o && imem_gnt_i;
   assign rsp           = (state == WAIT) && imem_rvalid_i;
   assign push          = rsp && !discard && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
   assign imem_addr_o   = fetch_pc;
   assign instr_valid_o = (count != '0);
   assign instr_o       = buf_instr[rd_ptr];
   assign instr_pc_o    = buf_pc[rd_ptr];

   // FSM, fetch PC, discard flag and FIFO bookkeeping; redirect overrides all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fetch_pc <= START_PC;
         out_pc   <= '0;
         discard  <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         case (state)
            IDLE:    state <= REQ;
            REQ:     if (grant) state <= WAIT;
            WAIT:    if (imem_rvalid_i) state <= REQ;
            default: state <= IDLE;
         endcase

         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
            out_pc   <= fetch_pc;
         end

         if (redirect_i) begin
            fetch_pc <= redirect_pc_i & WORD_MASK;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            // In-flight response still to come must be dropped when it lands.
            discard  <= ((state == WAIT) && !imem_rvalid_i) || grant;
         end else begin
            if (rsp) discard <= 1'b0;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
               count <= count + CNT_W'(1);
            end else if (!push && pop) begin
               count <= count - CNT_W'(1);
            end
         end
      end
   end

   // Instruction buffer storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            buf_pc[i]    <= '0;
            buf_instr[i] <= '0;
         end
      end else if (push) begin
         buf_pc[wr_ptr]    <= out_pc;
         buf_instr[wr_ptr] <= imem_rdata_i;
      end
   end

endmodule
